secure_boot_chain: RTL and testbench
====================================

# secure_boot_chain

Parametrised multi-stage secure-boot verifier that fetches NUM_STAGES images in sequence from external flash, checks each header's magic and version, hashes each payload into a LANES-wide lane digest, and compares that digest against a per-stage expected value. It sits between the flash controller and the core reset-release logic. boot_ready asserts only after every stage passes. Any failure locks the block in ERROR, with the failing stage and error code latched, until rst_n.

## Interface
- DATA_W, 32: flash word width, ≥32.
- ADDR_W, 32: flash byte-address width.
- NUM_STAGES, 2: images in the chain, 1..8.
- MAX_WORDS, 256: maximum payload words per stage. CNT_W = $clog2(MAX_WORDS+1).
- LANES, 8: hash lanes; digest width is LANES*DATA_W.
- TIMEOUT_CYC, 64: maximum cycles from flash_req to flash_ack.
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins the chain; honoured only in IDLE
- stage_base  in  NUM_STAGES*ADDR_W  per-stage flash byte base; stage s occupies slice s
- stage_len  in  NUM_STAGES*CNT_W  per-stage payload word count
- exp_digest  in  NUM_STAGES*LANES*DATA_W  per-stage expected digest
- min_version  in  16  anti-rollback floor
- flash_req  out  1  read request
- flash_addr  out  ADDR_W  byte address; held stable while flash_req=1 and no ack
- flash_ack  in  1  read data valid this cycle
- flash_rdata  in  DATA_W  read data; sampled only when flash_req&flash_ack
- stage_idx  out  3  stage currently being processed
- stage_ok  out  NUM_STAGES  bit s set when stage s passes
- boot_ready  out  1  high in DONE only
- violation  out  1  high in ERROR only
- err_code  out  3  0 none, 1 MAGIC, 2 ROLLBACK, 3 DIGEST, 4 TIMEOUT, 5 LEN
- err_stage  out  3  stage index at failure

## Operation
- States: IDLE → HDR → PAY → CMP → (NEXT → HDR) or DONE. Any failure goes to ERROR.
- IDLE: on start, stage_idx=0, lane accumulators cleared, go to HDR.
- HDR:
  - flash_addr = base.
  - On ack, the header word is {magic[31:16], version[15:0]}.
  - magic ≠ 16'hB007 → MAGIC.
  - version < min_version → ROLLBACK.
  - len=0 or len>MAX_WORDS → LEN.
  - Check priority: MAGIC > ROLLBACK > LEN.
- PAY:
  - Word i (0..len-1) is at base+4*(i+1).
  - On ack, acc[i mod LANES] ← rotl1(acc[i mod LANES]) ^ word.
  - Go to CMP after word len-1.
- CMP: the digest is {acc[LANES-1],…,acc[0]}.
  - Digest = exp_digest slice → set stage_ok[s].
  - Otherwise → DIGEST.
- NEXT: clear accumulators; increment stage_idx. If stage_idx == NUM_STAGES-1, go to DONE; otherwise go to HDR.
- DONE: boot_ready=1; start is ignored.
- ERROR:
  - violation=1, boot_ready=0, stage_ok cleared, flash_req=0.
  - err_code and err_stage are latched at entry.
  - start is ignored; only rst_n exits.
- Arithmetic:
  - Address increment is modulo 2^ADDR_W; wrap is not an error.
  - Word counter is CNT_W bits.
  - Version compare is unsigned.

## Timing
- Reset values: all outputs 0, state IDLE, accumulators 0.
- Reset is asynchronous; asserting it mid-fetch drops flash_req in the same cycle.
- start sampled at edge T → flash_req=1 with header address from T+1.
- Handshake:
  - A transfer completes on a cycle with flash_req&flash_ack.
  - The next address is presented in the following cycle, and flash_req stays high.
  - With flash_ack tied high, throughput is one word per cycle.
- Latency with ack tied high: per stage 1 (HDR) + len (PAY) + 1 (CMP) + 1 (NEXT) cycles. boot_ready rises the cycle after the last NEXT.
- Timeout:
  - A counter resets on each new request and on ack.
  - If it reaches TIMEOUT_CYC with flash_req high and no ack, the block enters ERROR (code 4) on the next edge.
  - An ack arriving on the timeout cycle wins.
- ack while flash_req=0 is ignored.
- violation and err_code become valid one cycle after the failing sample.

## Structure
- secure_boot_pkg holds: state enum; error-code constants; BOOT_MAGIC=16'hB007; rotl1 function.
- Sub-module boot_lane_hash (params DATA_W, LANES; ports clr, en, word, lane_sel, digest) holds the accumulators and the rotate-XOR update.
- The top level holds the FSM, address/word counters, timeout counter and compare logic.

## Test plan
All scenarios use NUM_STAGES=2 and LANES=4.
- Happy path:
  - Setup: both stages len=4, payload 1,2,3,4; headers 32'hB007_0003; min_version=2; exp_digest={4,3,2,1}; ack tied high.
  - Response: stage_ok=2'b11; boot_ready at cycle 1+2×7 after start; err_code=0.
- Rollback: stage 1 header 32'hB007_0001, min_version=2 → ERROR, err_code=2, err_stage=1, stage_ok=0, flash_req=0.
- Digest mismatch and lane wrap:
  - Setup: stage 0 len=5, words 1..5 → acc0=rotl1(1)^5=7; exp_digest set to {4,3,2,1}.
  - Response: err_code=3, err_stage=0.
- Timeout: flash_ack held low after the stage-0 header request → violation exactly TIMEOUT_CYC cycles after flash_req rose, err_code=4. An ack on that cycle instead → no error.
- Random ack stall: 30% random ack, happy-path images → identical digests and pass; flash_addr stable during stalls.
- Reset mid-PAY and start abuse:
  - rst_n low at word 2 → all outputs 0 immediately.
  - A restart then passes.
  - start pulsed during PAY has no effect.

Source files
------------

// File: rtl/secure_boot_pkg.sv
// Shared types, error codes and helpers for the secure-boot verifier.
package secure_boot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAY,
    ST_CMP,
    ST_NEXT,
    ST_DONE,
    ST_ERROR
  } boot_state_t;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_MAGIC    = 3'd1;
  localparam logic [2:0] ERR_ROLLBACK = 3'd2;
  localparam logic [2:0] ERR_DIGEST   = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT  = 3'd4;
  localparam logic [2:0] ERR_LEN      = 3'd5;

  localparam logic [15:0] BOOT_MAGIC = 16'hB007;

  // Widest word the rotate helper handles; callers zero-extend into it.
  localparam int ROT_MAX_W = 256;

  function automatic logic [ROT_MAX_W-1:0] rotl1(input logic [ROT_MAX_W-1:0] x,
                                                 input int unsigned w);
    logic [ROT_MAX_W-1:0] mask;
    mask = {ROT_MAX_W{1'b1}} >> (ROT_MAX_W - w);
    return ((x << 1) | (x >> (w - 1))) & mask;
  endfunction

endpackage

// File: rtl/boot_lane_hash.sv
// LANES-wide rotate-XOR accumulator; lane_sel picks which lane absorbs word.
module boot_lane_hash
  import secure_boot_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LANES  = 8,
  localparam int SEL_W = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    en,
  input  logic [DATA_W-1:0]       word,
  input  logic [SEL_W-1:0]        lane_sel,
  output logic [LANES*DATA_W-1:0] digest
);

  logic [DATA_W-1:0] acc [LANES];

  // NOTE: the accumulators are reset because their value is compared as-is
  // against the expected digest; an unreset start value would poison stage 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int l = 0; l < LANES; l++) acc[l] <= '0;
    end else if (clr) begin
      for (int l = 0; l < LANES; l++) acc[l] <= '0;
    end else if (en) begin
      acc[lane_sel] <= DATA_W'(rotl1(ROT_MAX_W'(acc[lane_sel]), DATA_W)) ^ word;
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_digest
    assign digest[l*DATA_W +: DATA_W] = acc[l];
  end

endmodule

// File: rtl/secure_boot_chain.sv
// Multi-stage secure-boot verifier: fetches header+payload per stage from
// flash, checks magic/version/length, hashes the payload and compares digests.
module secure_boot_chain
  import secure_boot_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int NUM_STAGES  = 2,
  parameter int MAX_WORDS   = 256,
  parameter int LANES       = 8,
  parameter int TIMEOUT_CYC = 64,
  localparam int CNT_W      = $clog2(MAX_WORDS + 1),
  localparam int DIG_W      = LANES * DATA_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [NUM_STAGES*ADDR_W-1:0] stage_base,
  input  logic [NUM_STAGES*CNT_W-1:0]  stage_len,
  input  logic [NUM_STAGES*DIG_W-1:0]  exp_digest,
  input  logic [15:0]                  min_version,
  output logic                         flash_req,
  output logic [ADDR_W-1:0]            flash_addr,
  input  logic                         flash_ack,
  input  logic [DATA_W-1:0]            flash_rdata,
  output logic [2:0]                   stage_idx,
  output logic [NUM_STAGES-1:0]        stage_ok,
  output logic                         boot_ready,
  output logic                         violation,
  output logic [2:0]                   err_code,
  output logic [2:0]                   err_stage
);

  localparam int SEL_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  boot_state_t state_q, state_d;

  logic [ADDR_W-1:0]     addr_q;
  logic [CNT_W-1:0]      word_q;
  logic [SEL_W-1:0]      lane_q;
  logic [TMO_W-1:0]      tmo_q;
  logic [NUM_STAGES-1:0] ok_q;
  logic [2:0]            err_code_q, err_stage_q, fail_code;

  logic              hash_clr, hash_en, tmo_hit, last_stage;
  logic [2:0]        nxt_idx;
  logic [ADDR_W-1:0] cur_base, nxt_base;
  logic [CNT_W-1:0]  cur_len;
  logic [DIG_W-1:0]  cur_exp, digest;

  assign last_stage = (stage_idx == 3'(NUM_STAGES - 1));
  assign nxt_idx    = last_stage ? stage_idx : stage_idx + 3'd1;
  assign cur_base   = stage_base[int'(stage_idx) * ADDR_W +: ADDR_W];
  assign nxt_base   = stage_base[int'(nxt_idx) * ADDR_W +: ADDR_W];
  assign cur_len    = stage_len[int'(stage_idx) * CNT_W +: CNT_W];
  assign cur_exp    = exp_digest[int'(stage_idx) * DIG_W +: DIG_W];

  // The current wait cycle is the TIMEOUT_CYC-th without an ack.
  assign tmo_hit = flash_req && !flash_ack && (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

  assign flash_req  = (state_q == ST_HDR) || (state_q == ST_PAY);
  assign flash_addr = addr_q;
  assign boot_ready = (state_q == ST_DONE);
  assign violation  = (state_q == ST_ERROR);
  assign stage_ok   = ok_q;
  assign err_code   = err_code_q;
  assign err_stage  = err_stage_q;

  boot_lane_hash #(
    .DATA_W (DATA_W),
    .LANES  (LANES)
  ) u_hash (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (hash_clr),
    .en       (hash_en),
    .word     (flash_rdata),
    .lane_sel (lane_q),
    .digest   (digest)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path through it can hold a stale value and infer a latch.
  always_comb begin
    state_d   = state_q;
    hash_clr  = 1'b0;
    hash_en   = 1'b0;
    fail_code = ERR_NONE;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_HDR;
          hash_clr = 1'b1;
        end
      end
      ST_HDR: begin
        if (flash_ack) begin
          if (flash_rdata[31:16] != BOOT_MAGIC)          fail_code = ERR_MAGIC;
          else if (flash_rdata[15:0] < min_version)      fail_code = ERR_ROLLBACK;
          else if (cur_len == '0 || cur_len > CNT_W'(MAX_WORDS)) fail_code = ERR_LEN;
          state_d = (fail_code == ERR_NONE) ? ST_PAY : ST_ERROR;
        end else if (tmo_hit) begin
          fail_code = ERR_TIMEOUT;
          state_d   = ST_ERROR;
        end
      end
      ST_PAY: begin
        if (flash_ack) begin
          hash_en = 1'b1;
          if (word_q == cur_len - CNT_W'(1)) state_d = ST_CMP;
        end else if (tmo_hit) begin
          fail_code = ERR_TIMEOUT;
          state_d   = ST_ERROR;
        end
      end
      ST_CMP: begin
        if (digest == cur_exp) begin
          state_d = ST_NEXT;
        end else begin
          fail_code = ERR_DIGEST;
          state_d   = ST_ERROR;
        end
      end
      ST_NEXT: begin
        hash_clr = 1'b1;
        state_d  = last_stage ? ST_DONE : ST_HDR;
      end
      ST_DONE, ST_ERROR: ;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      word_q      <= '0;
      lane_q      <= '0;
      tmo_q       <= '0;
      stage_idx   <= '0;
      ok_q        <= '0;
      err_code_q  <= ERR_NONE;
      err_stage_q <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            addr_q    <= stage_base[ADDR_W-1:0];
            stage_idx <= '0;
            word_q    <= '0;
            lane_q    <= '0;
            tmo_q     <= '0;
          end
        end
        ST_HDR, ST_PAY: begin
          if (flash_ack) begin
            // Address wraps modulo 2^ADDR_W by construction.
            addr_q <= addr_q + ADDR_W'(4);
            tmo_q  <= '0;
            if (state_q == ST_PAY) begin
              word_q <= word_q + CNT_W'(1);
              lane_q <= (lane_q == SEL_W'(LANES - 1)) ? '0 : lane_q + SEL_W'(1);
            end
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        ST_CMP: begin
          if (state_d == ST_NEXT) ok_q <= ok_q | (NUM_STAGES'(1) << stage_idx);
        end
        ST_NEXT: begin
          addr_q    <= nxt_base;
          stage_idx <= nxt_idx;
          word_q    <= '0;
          lane_q    <= '0;
          tmo_q     <= '0;
        end
        default: ;
      endcase
      if (state_d == ST_ERROR && state_q != ST_ERROR) begin
        err_code_q  <= fail_code;
        err_stage_q <= stage_idx;
        ok_q        <= '0;
      end
    end
  end

endmodule

// File: tb/tb_secure_boot_chain.sv
// Scoreboard bench: a flash responder serves images, a behavioural model
// predicts each boot outcome and read address, and monitors compare.
module tb_secure_boot_chain;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int NS  = 2;
  localparam int MW  = 16;
  localparam int LN  = 4;
  localparam int TMO = 16;
  localparam int CW  = $clog2(MW + 1);
  localparam int DGW = LN * DW;

  logic              clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [NS*AW-1:0]  stage_base = '0;
  logic [NS*CW-1:0]  stage_len = '0;
  logic [NS*DGW-1:0] exp_digest = '0;
  logic [15:0]       min_version = '0;
  logic              flash_req, flash_ack = 1'b0;
  logic [AW-1:0]     flash_addr;
  logic [DW-1:0]     flash_rdata = '0;
  logic [2:0]        stage_idx, err_code, err_stage;
  logic [NS-1:0]     stage_ok;
  logic              boot_ready, violation;

  secure_boot_chain #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_STAGES(NS), .MAX_WORDS(MW),
    .LANES(LN), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stage_base(stage_base),
    .stage_len(stage_len), .exp_digest(exp_digest), .min_version(min_version),
    .flash_req(flash_req), .flash_addr(flash_addr), .flash_ack(flash_ack),
    .flash_rdata(flash_rdata), .stage_idx(stage_idx), .stage_ok(stage_ok),
    .boot_ready(boot_ready), .violation(violation), .err_code(err_code),
    .err_stage(err_stage)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            pass;
    logic [2:0]    code;
    logic [2:0]    stg;
    logic [NS-1:0] ok;
    int            lat;
  } exp_t;

  exp_t          exp_q[$];
  logic [AW-1:0] addr_q[$];
  bit [31:0]     mem[bit [31:0]];

  logic [31:0]    cfg_base[NS];
  logic [31:0]    cfg_hdr[NS];
  int             cfg_len[NS];
  logic [31:0]    cfg_word[NS][32];
  logic [DGW-1:0] cfg_exp[NS];

  int checks = 0, errors = 0;
  int cyc = 0, start_edge = 0;
  int ack_mode = 0, stall_left = 0, run_stall = 0, xfer_cnt = 0;
  bit armed = 0, done = 0, prev_stall = 0;
  logic [AW-1:0] prev_addr = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  // Spec-level digest: lane i%LN absorbs word i as rotl1(lane) ^ word.
  function automatic logic [DGW-1:0] calc_digest(input int s);
    logic [31:0] acc[LN];
    for (int l = 0; l < LN; l++) acc[l] = '0;
    for (int i = 0; i < cfg_len[s] && i < 32; i++)
      acc[i % LN] = {acc[i % LN][30:0], acc[i % LN][31]} ^ cfg_word[s][i];
    return {acc[3], acc[2], acc[1], acc[0]};
  endfunction

  // Predicts outcome, latency (in edges after the start edge) and reads.
  task automatic model_push(input bit tmo_first, input int first_delay, input bit lat_valid);
    exp_t e;
    int lat;
    logic [31:0] a;
    e.pass = 1; e.code = 3'd0; e.stg = 3'd0; e.ok = '0;
    lat = first_delay;
    for (int s = 0; s < NS; s++) begin
      if (tmo_first && s == 0) begin
        e.pass = 0; e.code = 3'd4; lat = TMO;
        break;
      end
      a = cfg_base[s];
      addr_q.push_back(a);
      if (cfg_hdr[s][31:16] != 16'hB007)                    e.code = 3'd1;
      else if (cfg_hdr[s][15:0] < min_version)              e.code = 3'd2;
      else if (cfg_len[s] == 0 || cfg_len[s] > MW)          e.code = 3'd5;
      if (e.code != 3'd0) begin
        e.pass = 0; e.stg = 3'(s); lat += 1;
        break;
      end
      for (int i = 0; i < cfg_len[s]; i++) begin
        a = a + 32'd4;
        addr_q.push_back(a);
      end
      if (calc_digest(s) != cfg_exp[s]) begin
        e.pass = 0; e.code = 3'd3; e.stg = 3'(s); lat += cfg_len[s] + 2;
        break;
      end
      e.ok[s] = 1'b1;
      lat += cfg_len[s] + 3;
    end
    if (!e.pass) e.ok = '0;
    e.lat = lat_valid ? lat : -1;
    exp_q.push_back(e);
  endtask

  always @(posedge clk) cyc++;

  // Flash responder plus read-address monitor.
  always @(negedge clk) begin : responder
    bit ack_now;
    if (!rst_n) begin
      flash_ack  = 1'b0;
      prev_stall = 0;
      run_stall  = 0;
    end else begin
      if (flash_req && prev_stall) check("addr_stable", flash_addr, prev_addr);
      case (ack_mode)
        0:       ack_now = !(flash_req && stall_left > 0);
        1:       ack_now = (run_stall >= 8) || ($urandom_range(0, 99) < 30);
        default: ack_now = 1'b0;
      endcase
      if (ack_mode == 0 && flash_req && !ack_now) stall_left--;
      flash_ack   = ack_now;
      flash_rdata = mem.exists(flash_addr) ? mem[flash_addr] : 32'h0;
      if (flash_req && ack_now) begin
        xfer_cnt++;
        run_stall = 0;
        if (addr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_read: addr %0h, no read expected", flash_addr);
        end else begin
          check("read_addr", flash_addr, addr_q.pop_front());
        end
      end else if (flash_req) begin
        run_stall++;
      end
      prev_stall = flash_req && !ack_now;
      prev_addr  = flash_addr;
    end
  end

  // Outcome monitor: fires once per boot when DONE or ERROR appears.
  always @(negedge clk) begin : outcome_mon
    exp_t e;
    if (rst_n && armed && (boot_ready || violation)) begin
      armed = 0;
      done  = 1;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_outcome: boot_ready=%0b violation=%0b, none expected",
                 boot_ready, violation);
      end else begin
        e = exp_q.pop_front();
        check("boot_ready", boot_ready, e.pass);
        check("violation", violation, !e.pass);
        check("err_code", err_code, e.code);
        check("err_stage", err_stage, e.stg);
        check("stage_ok", stage_ok, e.ok);
        check("flash_req_end", flash_req, 0);
        if (e.lat >= 0) check("latency", cyc - start_edge, e.lat);
      end
    end
  end

  task automatic set_stage(input int s, input logic [31:0] base, input logic [31:0] hdr,
                           input int len, input bit seq);
    cfg_base[s] = base;
    cfg_hdr[s]  = hdr;
    cfg_len[s]  = len;
    for (int i = 0; i < 32; i++) cfg_word[s][i] = seq ? 32'(i + 1) : $urandom;
    cfg_exp[s] = calc_digest(s);
  endtask

  task automatic cfg_happy();
    min_version = 16'd2;
    set_stage(0, 32'h0000_1000, 32'hB007_0003, 4, 1);
    set_stage(1, 32'h0000_2000, 32'hB007_0003, 4, 1);
    cfg_exp[0] = {32'd4, 32'd3, 32'd2, 32'd1};
    cfg_exp[1] = {32'd4, 32'd3, 32'd2, 32'd1};
  endtask

  task automatic apply();
    mem.delete();
    for (int s = 0; s < NS; s++) begin
      mem[cfg_base[s]] = cfg_hdr[s];
      for (int i = 0; i < cfg_len[s] && i < 32; i++)
        mem[cfg_base[s] + 32'(4 * (i + 1))] = cfg_word[s][i];
      stage_base[s*AW +: AW]  = cfg_base[s];
      stage_len[s*CW +: CW]   = CW'(cfg_len[s]);
      exp_digest[s*DGW +: DGW] = cfg_exp[s];
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_flash_req"}, flash_req, 0);
    check({tag, "_flash_addr"}, flash_addr, 0);
    check({tag, "_boot_ready"}, boot_ready, 0);
    check({tag, "_violation"}, violation, 0);
    check({tag, "_err_code"}, err_code, 0);
    check({tag, "_err_stage"}, err_stage, 0);
    check({tag, "_stage_ok"}, stage_ok, 0);
    check({tag, "_stage_idx"}, stage_idx, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    exp_q.delete();
    addr_q.delete();
    armed = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // mode 0: ack high (first_delay stalls on first read); 1: random; 2: ack low.
  task automatic run_boot(input string tag, input int mode, input int first_delay,
                          input int abuse);
    exp_t e;
    int n;
    apply();
    ack_mode   = mode;
    stall_left = first_delay;
    model_push(mode == 2, first_delay, mode != 1);
    e = exp_q[$];
    @(negedge clk);
    start      = 1'b1;
    start_edge = cyc + 1;
    done       = 0;
    armed      = 1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
      start = (n == abuse);
    end
    start = 1'b0;
    check({tag, "_finished"}, done, 1);
    // A second start in DONE/ERROR must not restart the chain.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check({tag, "_sticky_req"}, flash_req, 0);
    check({tag, "_sticky_ready"}, boot_ready, e.pass);
    check({tag, "_sticky_viol"}, violation, !e.pass);
    check({tag, "_reads_drained"}, addr_q.size(), 0);
  endtask

  initial begin
    int x0, n;
    #1;
    check_zero("reset");
    do_reset();
    check_zero("post_reset");

    cfg_happy();
    run_boot("happy", 0, 0, 0);

    do_reset(); cfg_happy(); min_version = 16'd3;
    run_boot("ver_equal", 0, 0, 0);

    do_reset(); cfg_happy(); cfg_hdr[1] = 32'hB007_0001;
    run_boot("rollback", 0, 0, 0);

    do_reset(); cfg_happy();
    set_stage(0, 32'h0000_1000, 32'hB007_0003, 5, 1);
    cfg_exp[0] = {32'd4, 32'd3, 32'd2, 32'd1};
    run_boot("digest_bad", 0, 0, 0);

    do_reset(); cfg_happy();
    set_stage(0, 32'h0000_1000, 32'hB007_0003, 5, 1);
    cfg_exp[0] = {32'd4, 32'd3, 32'd2, 32'd7};
    run_boot("lane_wrap", 0, 0, 0);

    do_reset(); cfg_happy(); cfg_hdr[0] = 32'hB008_0003;
    run_boot("magic", 0, 0, 0);

    do_reset(); cfg_happy(); cfg_hdr[0] = 32'hDEAD_0001;
    run_boot("magic_over_rb", 0, 0, 0);

    do_reset(); cfg_happy(); cfg_len[1] = 0;
    run_boot("len_zero", 0, 0, 0);

    do_reset(); cfg_happy(); cfg_len[0] = MW + 1;
    run_boot("len_over", 0, 0, 0);

    do_reset(); cfg_happy(); cfg_hdr[1] = 32'hB007_0000; cfg_len[1] = 0;
    run_boot("rb_over_len", 0, 0, 0);

    do_reset(); cfg_happy();
    set_stage(0, 32'h0000_1000, 32'hB007_0003, MW, 1);
    run_boot("len_max", 0, 0, 0);

    do_reset(); cfg_happy();
    set_stage(0, 32'hFFFF_FFF8, 32'hB007_0003, 4, 1);
    run_boot("addr_wrap", 0, 0, 0);

    do_reset(); cfg_happy();
    run_boot("timeout", 2, 0, 0);

    do_reset(); cfg_happy();
    run_boot("ack_at_limit", 0, TMO - 1, 0);

    do_reset(); cfg_happy();
    run_boot("rand_ack_happy", 1, 0, 0);

    for (int k = 0; k < 6; k++) begin
      do_reset();
      min_version = 16'($urandom_range(0, 100));
      set_stage(0, 32'h1000_0000 + 32'($urandom_range(0, 1023) << 8),
                {16'hB007, min_version + 16'($urandom_range(0, 5))}, $urandom_range(1, MW), 0);
      set_stage(1, 32'h8000_0000 + 32'($urandom_range(0, 1023) << 8),
                {16'hB007, min_version + 16'($urandom_range(0, 5))}, $urandom_range(1, MW), 0);
      if ($urandom_range(0, 2) == 0)
        cfg_exp[k % NS] = cfg_exp[k % NS] ^ (DGW'(1) << $urandom_range(0, DGW - 1));
      run_boot("random", k % 2, 0, 0);
    end

    // Reset while the third payload word of stage 0 is being requested.
    do_reset(); cfg_happy(); apply();
    ack_mode = 0; stall_left = 0;
    model_push(0, 0, 1);
    x0 = xfer_cnt;
    @(negedge clk); start = 1'b1; start_edge = cyc + 1; done = 0; armed = 1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (xfer_cnt - x0 < 3 && n < 100) begin
      @(negedge clk); #1; n++;
    end
    check("mid_pay_reached", xfer_cnt - x0, 3);
    @(posedge clk); #1;
    check("mid_pay_addr", flash_addr, 32'h0000_100C);
    check("mid_pay_req", flash_req, 1);
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    do_reset();
    cfg_happy();
    run_boot("restart_abuse", 0, 0, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
